// File: rtl/spi_secondary_mode.sv
// SPI secondary endpoint. It oversamples the SPI pins in the clk domain and moves words over
// valid/ready on the receive side and over a per-word fetch on the transmit side.
module spi_secondary_mode #(
    parameter int WordBits = 8,
    parameter bit Cpol     = 1'b0,
    parameter bit Cpha     = 1'b0,
    parameter bit MsbFirst = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sck,
    input  logic                cs_n,
    input  logic                in_bit,
    output logic                out_bit,
    output logic [WordBits-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_overrun,
    input  logic [WordBits-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_load,
    output logic                tx_underrun,
    output logic                busy
);

    localparam int CountBits = $clog2(WordBits + 1);
    localparam logic [CountBits-1:0] LastBit = CountBits'(WordBits - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic [2:0]            sck_sync;
    logic [2:0]            cs_sync;
    logic [2:0]            in_sync;
    logic [CountBits-1:0]  bit_count;
    logic [WordBits-1:0]   rx_shift;
    logic [WordBits-1:0]   tx_shift;
    logic [WordBits-1:0]   rx_next;
    logic [WordBits-1:0]   tx_word;
    logic                  seen_sample;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  sample_edge;
    logic                  shift_edge;
    logic                  cs_fall;
    logic                  cs_rise;

    function automatic logic head_bit(input logic [WordBits-1:0] w);
        return MsbFirst ? w[WordBits-1] : w[0];
    endfunction

    function automatic logic [WordBits-1:0] advance(input logic [WordBits-1:0] w);
        return MsbFirst ? (w << 1) : (w >> 1);
    endfunction

    // Idle levels are the reset values so no spurious edge appears after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync <= {3{Cpol}};
            cs_sync  <= 3'b111;
            in_sync  <= 3'b000;
        end else begin
            sck_sync <= {sck_sync[1:0], sck};
            cs_sync  <= {cs_sync[1:0], cs_n};
            in_sync  <= {in_sync[1:0], in_bit};
        end
    end

    // SCK is normalised by Cpol so "active" means away from the idle level
    assign lead_edge   = (sck_sync[1] ^ Cpol) & ~(sck_sync[2] ^ Cpol);
    assign trail_edge  = ~(sck_sync[1] ^ Cpol) & (sck_sync[2] ^ Cpol);
    assign sample_edge = Cpha ? trail_edge : lead_edge;
    assign shift_edge  = Cpha ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_sync[1] & cs_sync[2];
    assign cs_rise     = cs_sync[1] & ~cs_sync[2];

    // MOSI is stable for a whole half period before the sample edge, so the oldest tap is safe
    assign rx_next = MsbFirst ? {rx_shift[WordBits-2:0], in_sync[2]}
                              : {in_sync[2], rx_shift[WordBits-1:1]};
    assign tx_word = tx_valid ? tx_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_count   <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            seen_sample <= 1'b0;
            out_bit     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_load     <= 1'b0;
            tx_underrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            tx_load     <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state       <= ACTIVE;
                        busy        <= 1'b1;
                        bit_count   <= '0;
                        seen_sample <= 1'b0;
                        tx_load     <= 1'b1;
                        tx_underrun <= ~tx_valid;
                        // With Cpha=0 the first bit must be on the wire before the first SCK edge
                        if (!Cpha) begin
                            out_bit  <= head_bit(tx_word);
                            tx_shift <= advance(tx_word);
                        end else begin
                            out_bit  <= 1'b0;
                            tx_shift <= tx_word;
                        end
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_bit   <= 1'b0;
                        bit_count <= '0;
                    end else if (sample_edge) begin
                        rx_shift    <= rx_next;
                        seen_sample <= 1'b1;
                        if (bit_count == LastBit) begin
                            bit_count   <= '0;
                            tx_load     <= 1'b1;
                            tx_underrun <= ~tx_valid;
                            tx_shift    <= tx_word;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            bit_count <= bit_count + CountBits'(1);
                        end
                    end else if (shift_edge && (Cpha || seen_sample)) begin
                        out_bit  <= head_bit(tx_shift);
                        tx_shift <= advance(tx_shift);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
